membus_core_responder: RTL and testbench

Slave-side responder for the PDP-6 memory bus. It implements one 32K×36 core memory module that answers master cycles carrying read, write, and read-modify-write requests. It sits on one slave port of the bus connector. It drives address acknowledge, read restart and read data onto the OR-combined bus, and accepts write data on write restart.

---
 rtl/membus_pkg.sv | 31 +++
 rtl/membus_core_array.sv | 26 ++
 rtl/membus_core_responder.sv | 137 +++++++++++++
 tb/tb_membus_core_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/membus_pkg.sv
// Shared types and sizing for the PDP-6 core memory responder.
package membus_pkg;

   localparam int WORD_W = 36;
   localparam int ADDR_W = 15;
   localparam int SEL_W  = 4;
   localparam int LAT_W  = 4;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      ACK,
      READ,
      WAITWR
   } state_t;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef struct packed {
      addr_t ma;
      logic  rd;
      logic  wr;
   } req_t;

   typedef struct packed {
      logic  vld;
      word_t dat;
   } wr_pend_t;

endpackage

// File: rtl/membus_core_array.sv
// 32K x 36 single-port core array: one read or one write per cycle.
// Latency: read data registered, valid the cycle after rd_en.
// Backpressure: none; the caller never issues read and write together.
module membus_core_array
   import membus_pkg::*;
(
   input  logic  clk,
   input  logic  rd_en,
   input  logic  wr_en,
   input  addr_t addr,
   input  word_t wr_dat,
   output word_t rd_dat
);

   word_t mem [DEPTH];

   // rd_dat holds its value between reads so the responder can present it late.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_dat;
      end else if (rd_en) begin
         rd_dat <= mem[addr];
      end
   end

endmodule

// File: rtl/membus_core_responder.sv
// PDP-6 memory-bus slave for one 32K x 36 core module; optional MEMBUS_WR_TIMEOUT_EN aborts stalled writes.
// Latency: addr_ack one cycle after selection, rd_rs READ_LAT cycles after addr_ack.
// Backpressure: none; waits for the master's wr_rs, a new rq_cyc edge outside IDLE is ignored.
module membus_core_responder
   import membus_pkg::*;
#(
   parameter logic [SEL_W-1:0] SEL_CODE   = 4'b0000,
   parameter int               READ_LAT   = 2,
   parameter int               WR_TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         membus_rq_cyc,
   input  logic         membus_rd_rq,
   input  logic         membus_wr_rq,
   input  logic         membus_wr_rs,
   input  logic [21:35] membus_ma,
   input  logic [18:21] membus_sel,
   input  logic         membus_fmc_select,
   input  logic [0:35]  membus_mb_in,
   output logic         membus_addr_ack,
   output logic         membus_rd_rs,
   output logic [0:35]  membus_mb_out
);

`ifdef MEMBUS_WR_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif
   localparam int TO_W = $clog2(WR_TIMEOUT + 1);

   state_t           state, state_nxt;
   req_t             req_q;
   wr_pend_t         pend;
   logic             rq_prev;
   logic [LAT_W-1:0] lat_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic             select;
   logic             lat_last;
   logic             to_expired;
   logic             ram_rd;
   logic             ram_wr;
   word_t            ram_wr_dat;
   word_t            ram_rd_dat;
   logic             rd_rs;

   assign select = membus_rq_cyc & ~rq_prev & ~membus_fmc_select
                 & (membus_sel == SEL_CODE) & (membus_rd_rq | membus_wr_rq);

   assign lat_last   = (lat_cnt == LAT_W'(READ_LAT - 1));
   assign to_expired = TO_EN & (to_cnt == TO_W'(WR_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rq_prev <= 1'b0;
         lat_cnt <= '0;
         req_q   <= '0;
      end else begin
         state   <= state_nxt;
         rq_prev <= membus_rq_cyc;
         lat_cnt <= (state == READ) ? lat_cnt + LAT_W'(1) : '0;
         if (state == IDLE && select) begin
            req_q <= '{ma: membus_ma, rd: membus_rd_rq, wr: membus_wr_rq};
         end
      end
   end

   // An early wr_rs keeps its own data; the bus word may be gone by WAITWR.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= '0;
      end else if ((state == ACK || state == READ) && req_q.wr
                   && membus_wr_rs && !pend.vld) begin
         pend <= '{vld: 1'b1, dat: word_t'(membus_mb_in)};
      end else if (state == WAITWR || state == IDLE) begin
         pend.vld <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || state != WAITWR) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   always_comb begin
      state_nxt       = state;
      ram_rd          = 1'b0;
      ram_wr          = 1'b0;
      ram_wr_dat      = pend.vld ? pend.dat : word_t'(membus_mb_in);
      membus_addr_ack = 1'b0;
      rd_rs           = 1'b0;
      case (state)
         IDLE: begin
            if (select) state_nxt = ACK;
         end
         ACK: begin
            membus_addr_ack = 1'b1;
            ram_rd          = 1'b1;
            state_nxt       = READ;
         end
         READ: begin
            if (lat_last) begin
               rd_rs     = req_q.rd;
               state_nxt = req_q.wr ? WAITWR : IDLE;
            end
         end
         WAITWR: begin
            if (pend.vld || membus_wr_rs) begin
               ram_wr    = ~reset;
               state_nxt = IDLE;
            end else if (to_expired) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   membus_core_array u_array (
      .clk    (clk),
      .rd_en  (ram_rd),
      .wr_en  (ram_wr),
      .addr   (req_q.ma),
      .wr_dat (ram_wr_dat),
      .rd_dat (ram_rd_dat)
   );

   // The bus ORs every slave, so anything but the rd_rs cycle must be zero.
   assign membus_rd_rs  = rd_rs;
   assign membus_mb_out = rd_rs ? ram_rd_dat : '0;

endmodule

// File: tb/tb_membus_core_responder.sv
// Bench for membus_core_responder: vector table of bus cycles plus reset and timeout sequences.
module tb_membus_core_responder;

   localparam int          READ_LAT = 2;
   localparam logic [3:0]  SEL      = 4'b0000;
   localparam logic [35:0] JUNK     = 36'o525252525252;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         rq_cyc = 1'b0, rd_rq = 1'b0, wr_rq = 1'b0, wr_rs = 1'b0, fmc = 1'b0;
   logic [21:35] ma = '0;
   logic [18:21] sel = SEL;
   logic [0:35]  mb_in = '0;
   logic         addr_ack, rd_rs;
   logic [0:35]  mb_out;

   int errors = 0;
   int checks = 0;
   int rs_count = 0;
   bit mon_en = 1'b0;
   logic [35:0] exp_q[$];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [14:0] ma;
      logic [3:0]  sel;
      logic        fmc;
      logic        early;
      int          wdly;
      logic [35:0] wdat;
      logic        respond;
      logic [35:0] exp_dat;
   } vec_t;

   vec_t vecs[$];

   membus_core_responder #(
      .SEL_CODE   (SEL),
      .READ_LAT   (READ_LAT),
      .WR_TIMEOUT (8)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .membus_rq_cyc     (rq_cyc),
      .membus_rd_rq      (rd_rq),
      .membus_wr_rq      (wr_rq),
      .membus_wr_rs      (wr_rs),
      .membus_ma         (ma),
      .membus_sel        (sel),
      .membus_fmc_select (fmc),
      .membus_mb_in      (mb_in),
      .membus_addr_ack   (addr_ack),
      .membus_rd_rs      (rd_rs),
      .membus_mb_out     (mb_out)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0o expected %0o at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic vec_t mk(input logic rd, input logic wr, input logic [14:0] a,
                               input logic [3:0] s, input logic f, input logic early,
                               input int wdly, input logic [35:0] wdat,
                               input logic respond, input logic [35:0] exp_dat);
      vec_t v;
      v.rd = rd; v.wr = wr; v.ma = a; v.sel = s; v.fmc = f; v.early = early;
      v.wdly = wdly; v.wdat = wdat; v.respond = respond; v.exp_dat = exp_dat;
      return v;
   endfunction

   // Scoreboard: every rd_rs pops one expected word; mb_out must be zero otherwise.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rd_rs) begin
            rs_count++;
            if (exp_q.size() == 0) begin
               check("unexpected_rd_rs", 36'd1, 36'd0);
            end else begin
               check("rd_data", mb_out, exp_q.pop_front());
            end
         end else begin
            check("mb_out_idle", mb_out, 36'd0);
         end
      end
   end

   task automatic run_vec(input vec_t v);
      bit saw;
      int rs0;
      @(negedge clk);
      rq_cyc = 1'b1; rd_rq = v.rd; wr_rq = v.wr; ma = v.ma; sel = v.sel; fmc = v.fmc;
      rs0 = rs_count;
      if (!v.respond) begin
         saw = 1'b0;
         repeat (20) begin
            @(negedge clk);
            if (addr_ack) saw = 1'b1;
         end
         check("no_ack", 36'(saw), 36'd0);
      end else begin
         if (v.rd) exp_q.push_back(v.exp_dat);
         @(negedge clk);
         check("addr_ack", 36'(addr_ack), 36'd1);
         if (v.early) begin
            wr_rs = 1'b1; mb_in = v.wdat;
         end
         @(negedge clk);
         wr_rs = 1'b0; mb_in = JUNK;
         check("ack_drop", 36'(addr_ack), 36'd0);
         repeat (READ_LAT - 1) @(negedge clk);
         check("rd_rs_cycle", 36'(rd_rs), 36'(v.rd));
         if (v.wr) begin
            if (!v.early) begin
               repeat (v.wdly) @(negedge clk);
               wr_rs = 1'b1; mb_in = v.wdat;
               @(negedge clk);
               wr_rs = 1'b0; mb_in = JUNK;
            end else begin
               @(negedge clk);
            end
         end
      end
      rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; fmc = 1'b0; sel = SEL;
      #1;
      check("rd_rs_once", 36'(rs_count - rs0), 36'(v.rd && v.respond));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs.push_back(mk(0, 1, 15'o01234, SEL, 0, 0, 1, 36'o123456701234, 1, 36'd0));
      vecs.push_back(mk(1, 0, 15'o01234, SEL, 0, 0, 0, 36'd0, 1, 36'o123456701234));
      vecs.push_back(mk(0, 1, 15'o00100, SEL, 0, 0, 2, 36'o000111222333, 1, 36'd0));
      vecs.push_back(mk(1, 1, 15'o00100, SEL, 0, 0, 4, 36'o777000777000, 1, 36'o000111222333));
      vecs.push_back(mk(1, 0, 15'o00100, SEL, 0, 0, 0, 36'd0, 1, 36'o777000777000));
      vecs.push_back(mk(0, 1, 15'o77777, SEL, 0, 1, 0, 36'o000000000001, 1, 36'd0));
      vecs.push_back(mk(1, 0, 15'o77777, SEL, 0, 0, 0, 36'd0, 1, 36'o000000000001));
      vecs.push_back(mk(1, 0, 15'o01234, 4'b0101, 0, 0, 0, 36'd0, 0, 36'd0));
      vecs.push_back(mk(1, 0, 15'o01234, SEL, 1, 0, 0, 36'd0, 0, 36'd0));
      vecs.push_back(mk(0, 0, 15'o01234, SEL, 0, 0, 0, 36'd0, 0, 36'd0));
      vecs.push_back(mk(1, 0, 15'o01234, SEL, 0, 0, 0, 36'd0, 1, 36'o123456701234));

      repeat (3) @(negedge clk);
      check("reset_addr_ack", 36'(addr_ack), 36'd0);
      check("reset_rd_rs", 36'(rd_rs), 36'd0);
      check("reset_mb_out", mb_out, 36'd0);
      reset = 1'b0;
      mon_en = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Stray wr_rs while idle must not touch the array.
      @(negedge clk);
      wr_rs = 1'b1; mb_in = 36'o42;
      @(negedge clk);
      wr_rs = 1'b0; mb_in = JUNK;
      run_vec(mk(1, 0, 15'o77777, SEL, 0, 0, 0, 36'd0, 1, 36'o000000000001));

      // Reset during READ of an rd+wr cycle, with a wr_rs that would otherwise go pending.
      @(negedge clk);
      rq_cyc = 1'b1; rd_rq = 1'b1; wr_rq = 1'b1; ma = 15'o00100;
      @(negedge clk);
      check("rst_seq_ack", 36'(addr_ack), 36'd1);
      @(negedge clk);
      reset = 1'b1; rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0;
      wr_rs = 1'b1; mb_in = 36'o111;
      @(negedge clk);
      reset = 1'b0; wr_rs = 1'b0; mb_in = JUNK;
      check("rst_mid_ack", 36'(addr_ack), 36'd0);
      check("rst_mid_rd_rs", 36'(rd_rs), 36'd0);
      check("rst_mid_mb_out", mb_out, 36'd0);
      run_vec(mk(1, 0, 15'o00100, SEL, 0, 0, 0, 36'd0, 1, 36'o777000777000));

`ifdef MEMBUS_WR_TIMEOUT_EN
      // rd+wr with no wr_rs: WAITWR runs 8 cycles, re-selection accepted on the first idle cycle.
      @(negedge clk);
      rq_cyc = 1'b1; rd_rq = 1'b1; wr_rq = 1'b1; ma = 15'o01234;
      exp_q.push_back(36'o123456701234);
      @(negedge clk);
      check("to_ack", 36'(addr_ack), 36'd1);
      repeat (READ_LAT) @(negedge clk);
      check("to_rd_rs", 36'(rd_rs), 36'd1);
      rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0;
      repeat (8) @(negedge clk);
      run_vec(mk(1, 0, 15'o01234, SEL, 0, 0, 0, 36'd0, 1, 36'o123456701234));
`endif

      repeat (3) @(negedge clk);
      check("sb_drained", 36'(exp_q.size()), 36'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
